// File: rtl/endpoint_sync_sched.sv
// Source-side a##1b end-point detector feeding a destination-rate a##1matched##1d checker,
// with a pending-match store bridging the two tick domains and saturating statistics.
module endpoint_sync_sched #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             src_tick,
   input  logic             dst_tick,
   input  logic             a_src,
   input  logic             b_src,
   input  logic             a_dst,
   input  logic             d_dst,
   input  logic             clr,
   output logic             ended_o,
   output logic             matched_o,
   output logic             seq_pass,
   output logic             seq_fail,
   output logic             busy,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] merge_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_M = 2'd1,
      WAIT_D = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             a_prev_q, a_prev_d;
   logic             pend_q, pend_d;
   logic             ended_q, ended_d;
   logic             matched_q, matched_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic [CNT_W-1:0] merge_cnt_q, merge_cnt_d;

   logic ended_now;
   logic matched_now;

   assign ended_now   = src_tick & a_prev_q & b_src;
   assign matched_now = dst_tick & (pend_q | ended_now);

   always_comb begin
      state_d     = state_q;
      a_prev_d    = a_prev_q;
      pend_d      = pend_q;
      ended_d     = ended_now;
      matched_d   = matched_now;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      merge_cnt_d = merge_cnt_q;

      if (src_tick) begin
         a_prev_d = a_src;
      end

      // dst_tick consumes any end point, including one arriving this very cycle
      if (dst_tick) begin
         pend_d = 1'b0;
      end else if (ended_now) begin
         pend_d = 1'b1;
         if (pend_q && (merge_cnt_q != '1)) begin
            merge_cnt_d = merge_cnt_q + 1'b1;
         end
      end

      if (dst_tick) begin
         case (state_q)
            IDLE: begin
               if (a_dst) begin
                  state_d = WAIT_M;
               end
            end
            WAIT_M: begin
               if (matched_now) begin
                  state_d = WAIT_D;
               end else begin
                  fail_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            WAIT_D: begin
               pass_d  = d_dst;
               fail_d  = ~d_dst;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      if (pass_d && (pass_cnt_q != '1)) begin
         pass_cnt_d = pass_cnt_q + 1'b1;
      end
      if (fail_d && (fail_cnt_q != '1)) begin
         fail_cnt_d = fail_cnt_q + 1'b1;
      end

      if (clr) begin
         state_d     = IDLE;
         a_prev_d    = 1'b0;
         pend_d      = 1'b0;
         ended_d     = 1'b0;
         matched_d   = 1'b0;
         pass_d      = 1'b0;
         fail_d      = 1'b0;
         pass_cnt_d  = '0;
         fail_cnt_d  = '0;
         merge_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_prev_q    <= 1'b0;
         pend_q      <= 1'b0;
         ended_q     <= 1'b0;
         matched_q   <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         pass_cnt_q  <= '0;
         fail_cnt_q  <= '0;
         merge_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         a_prev_q    <= a_prev_d;
         pend_q      <= pend_d;
         ended_q     <= ended_d;
         matched_q   <= matched_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         pass_cnt_q  <= pass_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         merge_cnt_q <= merge_cnt_d;
      end
   end

   assign ended_o   = ended_q;
   assign matched_o = matched_q;
   assign seq_pass  = pass_q;
   assign seq_fail  = fail_q;
   assign busy      = (state_q != IDLE);
   assign state_o   = state_q;
   assign pass_cnt  = pass_cnt_q;
   assign fail_cnt  = fail_cnt_q;
   assign merge_cnt = merge_cnt_q;

endmodule

// File: tb/tb_endpoint_sync_sched.sv
// Directed bench for endpoint_sync_sched: per-step expected pulse vectors go through a
// scoreboard queue and are compared when the DUT registers its outputs.
module tb_endpoint_sync_sched;

   localparam int unsigned CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             src_tick = 1'b0, dst_tick = 1'b0;
   logic             a_src = 1'b0, b_src = 1'b0, a_dst = 1'b0, d_dst = 1'b0, clr = 1'b0;
   logic             ended_o, matched_o, seq_pass, seq_fail, busy;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] pass_cnt, fail_cnt, merge_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int         due;
      logic [3:0] pulses;   // {ended, matched, pass, fail}
      string      tag;
   } exp_t;
   exp_t sb[$];

   endpoint_sync_sched #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .src_tick(src_tick), .dst_tick(dst_tick),
      .a_src(a_src), .b_src(b_src), .a_dst(a_dst), .d_dst(d_dst), .clr(clr),
      .ended_o(ended_o), .matched_o(matched_o), .seq_pass(seq_pass), .seq_fail(seq_fail),
      .busy(busy), .state_o(state_o), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .merge_cnt(merge_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the pulses expected right after the edge, then pop.
   task automatic step(input logic st, dt, as, bs, ad, dd, cl,
                       input logic [3:0] ex, input string tag);
      exp_t e;
      src_tick = st; dst_tick = dt; a_src = as; b_src = bs;
      a_dst = ad; d_dst = dd; clr = cl;
      sb.push_back('{cyc + 1, ex, tag});
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk(e.tag, {4'b0, ended_o, matched_o, seq_pass, seq_fail}, {4'b0, e.pulses});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2;
      chk("rst_pulses", {4'b0, ended_o, matched_o, seq_pass, seq_fail}, 8'h00);
      chk("rst_state",  {5'b0, busy, state_o}, 8'h00);
      chk("rst_cnts",   {2'b0, pass_cnt, fail_cnt, merge_cnt}, 8'h00);
      #10 rst_n = 1'b1;

      // Slow, unaligned ticks: end point held pending until a later dst_tick
      step(1,0,1,0,0,0,0, 4'b0000, "slow_a");
      step(0,0,0,1,0,0,0, 4'b0000, "slow_notick");
      step(1,0,0,1,0,0,0, 4'b1000, "slow_ended");
      step(0,0,0,0,0,0,0, 4'b0000, "slow_hold");
      step(0,1,0,0,0,0,0, 4'b0100, "slow_matched");
      step(0,0,0,0,0,0,0, 4'b0000, "slow_gap");
      step(0,1,0,0,0,0,0, 4'b0000, "slow_pend_cleared");

      // Both ticks high: pass
      step(1,1,1,0,1,0,0, 4'b0000, "pass_t0");
      chk("pass_t0_state", {5'b0, busy, state_o}, 8'h05);
      step(1,1,0,1,0,0,0, 4'b1100, "pass_t1");
      chk("pass_t1_state", {5'b0, busy, state_o}, 8'h06);
      step(1,1,0,0,0,1,0, 4'b0010, "pass_t2");
      chk("pass_cnt1", {6'b0, pass_cnt}, 8'h01);
      chk("pass_idle", {5'b0, busy, state_o}, 8'h00);
      step(1,1,0,0,0,0,0, 4'b0000, "pass_quiet");

      // No end point: fail at the WAIT_M tick, d_dst ignored
      step(1,1,0,0,1,0,0, 4'b0000, "fail_t0");
      step(1,1,0,0,0,1,0, 4'b0001, "fail_t1");
      chk("fail_cnt1", {6'b0, fail_cnt}, 8'h01);
      step(1,1,0,0,0,1,0, 4'b0000, "fail_d_ignored");
      // a_dst on the failing tick must not restart
      step(1,1,0,0,1,0,0, 4'b0000, "norst_t0");
      step(1,1,0,0,1,0,0, 4'b0001, "norst_fail");
      chk("norst_state", {5'b0, busy, state_o}, 8'h00);
      chk("fail_cnt2", {6'b0, fail_cnt}, 8'h02);
      step(1,1,0,0,0,0,0, 4'b0000, "norst_quiet");

      // dst_tick held low: three overlapping end points merge into one match
      step(1,0,1,0,0,0,0, 4'b0000, "merge_a");
      step(1,0,1,1,0,0,0, 4'b1000, "merge_e1");
      step(1,0,1,1,0,0,0, 4'b1000, "merge_e2");
      step(1,0,0,1,0,0,0, 4'b1000, "merge_e3");
      chk("merge_cnt2", {6'b0, merge_cnt}, 8'h02);
      step(0,1,0,0,0,0,0, 4'b0100, "merge_one_match");
      step(0,1,0,0,0,0,0, 4'b0000, "merge_no_second");

      // Bypass: ended_now and dst_tick together
      step(1,0,1,0,0,0,0, 4'b0000, "byp_a");
      step(1,1,0,1,0,0,0, 4'b1100, "byp_same_cycle");
      step(0,1,0,0,0,0,0, 4'b0000, "byp_pend_zero");
      chk("byp_merge_same", {6'b0, merge_cnt}, 8'h02);

      // clr wins over a simultaneous end point and clears all counters
      step(1,0,1,0,0,0,0, 4'b0000, "clr_a");
      step(1,1,0,1,0,0,1, 4'b0000, "clr_priority");
      chk("clr_cnts", {2'b0, pass_cnt, fail_cnt, merge_cnt}, 8'h00);
      step(0,1,0,0,0,0,0, 4'b0000, "clr_pend_gone");

      // Saturation of the 2-bit pass counter
      for (int i = 0; i < 5; i++) begin
         step(1,1,1,0,1,0,0, 4'b0000, "sat_t0");
         step(1,1,0,1,0,0,0, 4'b1100, "sat_t1");
         step(1,1,0,0,0,1,0, 4'b0010, "sat_t2");
      end
      chk("pass_sat", {6'b0, pass_cnt}, 8'h03);

      // Reset in WAIT_D aborts without a result pulse
      step(1,1,1,0,1,0,0, 4'b0000, "abort_t0");
      step(1,1,0,1,0,0,0, 4'b1100, "abort_t1");
      chk("abort_waitd", {5'b0, busy, state_o}, 8'h06);
      d_dst = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_pulses", {4'b0, ended_o, matched_o, seq_pass, seq_fail}, 8'h00);
      chk("abort_state",  {5'b0, busy, state_o}, 8'h00);
      chk("abort_cnts",   {2'b0, pass_cnt, fail_cnt, merge_cnt}, 8'h00);
      @(posedge clk);
      #1;
      chk("abort_held", {4'b0, ended_o, matched_o, seq_pass, seq_fail}, 8'h00);
      rst_n = 1'b1;
      step(1,1,0,0,0,1,0, 4'b0000, "abort_after1");
      step(1,1,0,0,0,0,0, 4'b0000, "abort_after2");
      chk("abort_cnts_after", {2'b0, pass_cnt, fail_cnt, merge_cnt}, 8'h00);

      n_cmp++;
      assert (sb.size() == 0) else begin
         n_bad++;
         $error("FAIL sb_drain: observed %0d expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
